inv_mix_columns_seq: RTL and testbench

- Iterative AES InvMixColumns unit for the decryption datapath; the inverse of the existing four-column combinational MixColumns stage.
- Accepts a 128-bit state over a valid/ready handshake and processes one 32-bit column per clock, using a single shared column multiplier.
- Returns the result over a second valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes/AddRoundKey in the iterative decryption round.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/inv_mix_column_word.sv | 39 +++
 rtl/inv_mix_columns_seq.sv | 96 +++++++++
 tb/tb_inv_mix_columns_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and FSM state type for the MixColumns datapath.
package aes_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned CNT_W    = $clog2(NUM_COLS);
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned COL_W    = NUM_COLS * BYTE_W;
    localparam int unsigned STATE_W  = NUM_COLS * COL_W;

    localparam logic [BYTE_W-1:0] POLY = 8'h1B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_t;

    // Multiply by x, reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
        return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? POLY : BYTE_W'(0));
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul_09(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul_0b(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul_0d(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul_0e(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Single-column InvMixColumns (0e 0b 0d 09 matrix); forward MixColumns selectable
// through `mode` when INV_MIX_FWD_MODE_EN is defined.
module inv_mix_column_word
    import aes_pkg::*;
(
`ifdef INV_MIX_FWD_MODE_EN
    input  logic             mode,
`endif
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    // Row 0 of each matrix; other rows reuse it on a byte-rotated column.
    function automatic logic [BYTE_W-1:0] inv_row(input logic [COL_W-1:0] w);
        return gf_mul_0e(w[31:24]) ^ gf_mul_0b(w[23:16]) ^ gf_mul_0d(w[15:8]) ^ gf_mul_09(w[7:0]);
    endfunction

    logic [COL_W-1:0] rot1, rot2, rot3;
    logic [COL_W-1:0] inv_col;

    assign rot1 = {col_in[23:0], col_in[31:24]};
    assign rot2 = {col_in[15:0], col_in[31:16]};
    assign rot3 = {col_in[7:0],  col_in[31:8]};

    assign inv_col = {inv_row(col_in), inv_row(rot1), inv_row(rot2), inv_row(rot3)};

`ifdef INV_MIX_FWD_MODE_EN
    function automatic logic [BYTE_W-1:0] fwd_row(input logic [COL_W-1:0] w);
        return xtime(w[31:24]) ^ xtime(w[23:16]) ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    logic [COL_W-1:0] fwd_col;
    assign fwd_col = {fwd_row(col_in), fwd_row(rot1), fwd_row(rot2), fwd_row(rot3)};
    assign col_out = mode ? fwd_col : inv_col;
`else
    assign col_out = inv_col;
`endif

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: one column per clock through a shared column unit.
// Define INV_MIX_FWD_MODE_EN to add a `mode` port selecting forward MixColumns.
module inv_mix_columns_seq
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:STATE_W-1] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:STATE_W-1] out_state
`ifdef INV_MIX_FWD_MODE_EN
    ,
    input  logic               mode
`endif
);

    fsm_state_t         state;
    logic [CNT_W-1:0]   col;
    logic [0:STATE_W-1] work;
    logic               live;
    logic               accept;
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;
`ifdef INV_MIX_FWD_MODE_EN
    logic               mode_q;
`endif

    // Ready is held low for the first cycle out of reset via `live`.
    assign in_ready = live && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        col_in = work[0 +: COL_W];
        for (int c = 1; c < NUM_COLS; c++) begin
            if (col == CNT_W'(c)) col_in = work[c*COL_W +: COL_W];
        end
    end

    inv_mix_column_word u_word (
`ifdef INV_MIX_FWD_MODE_EN
        .mode    (mode_q),
`endif
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            work      <= '0;
            live      <= 1'b0;
            out_valid <= 1'b0;
            out_state <= '0;
`ifdef INV_MIX_FWD_MODE_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            live <= 1'b1;
            // Capture covers both IDLE and the DONE-with-handshake overlap.
            if (accept) begin
                work  <= in_state;
                col   <= '0;
                state <= BUSY;
`ifdef INV_MIX_FWD_MODE_EN
                mode_q <= mode;
`endif
            end
            case (state)
                IDLE: ;
                BUSY: begin
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (col == CNT_W'(c)) work[c*COL_W +: COL_W] <= col_out;
                    end
                    col <= col + CNT_W'(1);
                    if (col == CNT_W'(NUM_COLS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_state <= {work[0:STATE_W-COL_W-1], col_out};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!accept) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq against a GF(2^8) matrix reference model.
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;
`ifdef INV_MIX_FWD_MODE_EN
    logic         mode;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
`ifdef INV_MIX_FWD_MODE_EN
        ,
        .mode      (mode)
`endif
    );

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    // Circulant matrix times each column; inv selects 0e0b0d09, else 02030101.
    function automatic logic [0:127] mix_model(input logic [0:127] s, input bit inv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [0:127] r;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], s[32*c + 8*j +: 8]);
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic accept(input logic [0:127] s, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_state = s;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(output logic [0:127] r, output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 50) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        r = out_state;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [0:127] s, output logic [0:127] r, output int lat, output bit busy_ok);
        bit ok;
        accept(s, ok);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        collect(r, lat, busy_ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_state !== 128'h0) begin failures++; $display("FAIL reset_out_state: got %h want 0", out_state); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_cols();
        logic [31:0]  vin  [4] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6};
        logic [31:0]  vexp [4] = '{32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5};
        logic [0:127] r, exp;
        int           lat;
        bit           busy_ok;
        for (int i = 0; i < 4; i++) begin
            exp = {vexp[i], 96'h010101010101010101010101};
            run_block({vin[i], 96'h010101010101010101010101}, r, lat, busy_ok);
            checks++;
            if (r !== exp) begin failures++; $display("FAIL single_col_%0d: got %h want %h", i, r, exp); end
        end
    endtask

    task automatic test_full_state();
        logic [0:127] r;
        logic [0:127] exp;
        int           lat;
        bit           busy_ok;
        exp = 128'hdb135345_f20a225c_2d26314c_d4d4d4d5;
        run_block(128'h8e4da1bc_9fdc589d_4d7ebdf8_d5d5d7d6, r, lat, busy_ok);
        checks++;
        if (r !== exp) begin failures++; $display("FAIL full_state: got %h want %h", r, exp); end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL full_latency: got %0d want 4", lat); end
        checks++;
        if (!busy_ok) begin failures++; $display("FAIL busy_in_ready: got 1 want 0"); end
    endtask

    task automatic test_backpressure();
        logic [0:127] a, b, r, held;
        int           n, lat;
        bit           ok, stable, busy_ok;
        a = rand_state();
        b = rand_state();
        out_ready = 1'b0;
        accept(a, ok);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (out_state !== mix_model(a, 1'b1) || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_first: got %h valid %b want %h", out_state, out_valid, mix_model(a, 1'b1));
        end
        held   = out_state;
        stable = 1'b1;
        // Junk offered during the stall must be ignored.
        in_valid = 1'b1;
        repeat (10) begin
            in_state = rand_state();
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_state !== held || in_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin failures++; $display("FAIL bp_hold: got %h want %h held", out_state, held); end
        @(negedge clk);
        in_state  = b;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_handshake: got %b want 0", out_valid); end
        collect(r, lat, busy_ok);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL bp_next_latency: got %0d want 4", lat); end
        checks++;
        if (r !== mix_model(b, 1'b1)) begin failures++; $display("FAIL bp_next_value: got %h want %h", r, mix_model(b, 1'b1)); end
    endtask

    task automatic test_reset_mid();
        logic [0:127] a, c, r;
        int           lat;
        bit           ok, busy_ok;
        a = rand_state();
        c = rand_state();
        accept(a, ok);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++;
        if (out_state !== 128'h0) begin failures++; $display("FAIL midrst_state: got %h want 0", out_state); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_partial: got %b want 0", out_valid); end
        run_block(c, r, lat, busy_ok);
        checks++;
        if (r !== mix_model(c, 1'b1)) begin failures++; $display("FAIL midrst_fresh: got %h want %h", r, mix_model(c, 1'b1)); end
    endtask

    task automatic test_round_trip();
        logic [0:127] s, r;
        int           lat;
        bit           busy_ok;
        for (int i = 0; i < 1000; i++) begin
            s = rand_state();
            run_block(mix_model(s, 1'b0), r, lat, busy_ok);
            checks++;
            if (r !== s) begin failures++; $display("FAIL round_trip_%0d: got %h want %h", i, r, s); end
        end
    endtask

`ifdef INV_MIX_FWD_MODE_EN
    task automatic test_mode_round_trip();
        logic [0:127] s, m, r;
        int           lat;
        bit           busy_ok;
        for (int i = 0; i < 200; i++) begin
            s    = rand_state();
            mode = 1'b1;
            run_block(s, m, lat, busy_ok);
            checks++;
            if (m !== mix_model(s, 1'b0)) begin failures++; $display("FAIL fwd_mode_%0d: got %h want %h", i, m, mix_model(s, 1'b0)); end
            mode = 1'b0;
            run_block(m, r, lat, busy_ok);
            checks++;
            if (r !== s) begin failures++; $display("FAIL mode_round_trip_%0d: got %h want %h", i, r, s); end
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
`ifdef INV_MIX_FWD_MODE_EN
        mode      = 1'b0;
`endif
        test_reset();
        test_single_cols();
        test_full_state();
        test_backpressure();
        test_reset_mid();
        test_round_trip();
`ifdef INV_MIX_FWD_MODE_EN
        test_mode_round_trip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
